nios_audio_sample_fifo_in: RTL and testbench



---
 rtl/nios_audio_sample_fifo_in.sv | 140 ++++++++++++++
 tb/tb_nios_audio_sample_fifo_in.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_audio_sample_fifo_in.sv
// Avalon-MM audio sample input FIFO with sticky error flags, level threshold and maskable irq.
// Optional macro NIOS_AUDIO_SAMPLE_FIFO_IN_SYNC_EN adds a two-flop input synchronizer with in_valid edge detect.
module nios_audio_sample_fifo_in #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [2:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    input  logic [DATA_WIDTH-1:0] in_port,
    input  logic                  in_valid
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] sample;
    logic                  push_req;

`ifdef NIOS_AUDIO_SAMPLE_FIFO_IN_SYNC_EN
    logic [DATA_WIDTH-1:0] port_s1, port_s2;
    logic                  valid_s1, valid_s2, valid_s3;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_s1  <= '0;
            port_s2  <= '0;
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            valid_s3 <= 1'b0;
        end else begin
            port_s1  <= in_port;
            port_s2  <= port_s1;
            valid_s1 <= in_valid;
            valid_s2 <= valid_s1;
            valid_s3 <= valid_s2;
        end
    end

    assign sample   = port_s2;
    assign push_req = valid_s2 & ~valid_s3;
`else
    assign sample   = in_port;
    assign push_req = in_valid;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level, thresh;
    logic [2:0]            irq_mask;
    logic                  overflow, underflow;

    logic rd_en, wr_en, empty, full, at_thresh;
    logic pop, push_ok, overflow_evt, underflow_evt;
    logic clr_ovf, clr_udf, irq_next;
    logic [31:0] rd_mux;
    logic unused_ok;

    assign rd_en     = chipselect & read;
    assign wr_en     = chipselect & write;
    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign at_thresh = (level >= thresh);

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands when paired with a pop.
    assign pop           = rd_en && (address == 3'd0) && !empty;
    assign underflow_evt = rd_en && (address == 3'd0) && empty;
    assign push_ok       = push_req && (!full || pop);
    assign overflow_evt  = push_req && full && !pop;

    assign clr_ovf = wr_en && (address == 3'd1) && writedata[2];
    assign clr_udf = wr_en && (address == 3'd1) && writedata[3];

    assign irq_next = (irq_mask[0] & ~empty) | (irq_mask[1] & at_thresh)
                    | (irq_mask[2] & (overflow | underflow));

    assign unused_ok = ^writedata;

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: if (!empty) rd_mux[DATA_WIDTH-1:0] = mem[rd_ptr];
            3'd1: begin
                rd_mux[0]          = empty;
                rd_mux[1]          = full;
                rd_mux[2]          = overflow;
                rd_mux[3]          = underflow;
                rd_mux[4]          = at_thresh;
                rd_mux[8 +: LVL_W] = level;
            end
            3'd2:    rd_mux[2:0]         = irq_mask;
            3'd3:    rd_mux[LVL_W-1:0]   = thresh;
            3'd4:    rd_mux[DATA_WIDTH-1:0] = sample;
            default: rd_mux = '0;
        endcase
    end

    // NOTE: sample storage has no reset; emptiness is tracked by level and pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            irq_mask  <= '0;
            thresh    <= LVL_W'(DEPTH / 2);
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);

            if (push_ok && !pop)      level <= level + LVL_W'(1);
            else if (!push_ok && pop) level <= level - LVL_W'(1);

            // A new error event outranks a simultaneous W1C clear.
            overflow  <= overflow_evt  | (overflow  & ~clr_ovf);
            underflow <= underflow_evt | (underflow & ~clr_udf);

            if (wr_en && address == 3'd2) irq_mask <= writedata[2:0];
            if (wr_en && address == 3'd3) thresh   <= writedata[LVL_W-1:0];

            if (rd_en) readdata <= rd_mux;
            irq <= irq_next;
        end
    end

endmodule

// File: tb/tb_nios_audio_sample_fifo_in.sv
// Self-checking bench for nios_audio_sample_fifo_in (default build, DEPTH=16, DATA_WIDTH=32).
// Expected DATA reads come from a scoreboard queue filled as samples are pushed.
module tb_nios_audio_sample_fifo_in;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, read, write, in_valid;
    logic [2:0]  address;
    logic [31:0] writedata, readdata, in_port;
    logic        irq;

    nios_audio_sample_fifo_in #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .irq(irq), .in_port(in_port), .in_valid(in_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    int          m_thr = DEPTH / 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int lvl;
        lvl  = exp_q.size();
        s    = '0;
        s[0] = (lvl == 0);
        s[1] = (lvl == DEPTH);
        s[2] = m_ovf;
        s[3] = m_udf;
        s[4] = (lvl >= m_thr);
        s[12:8] = 5'(lvl);
        return s;
    endfunction

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        cycle();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic model_pop(output logic [31:0] e);
        if (exp_q.size() == 0) begin
            e = '0;
            m_udf = 1'b1;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic model_push(input logic [31:0] v);
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic push_sample(input logic [31:0] v);
        model_push(v);
        in_port = v; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic read_data(input string tag);
        logic [31:0] e, d;
        model_pop(e);
        bus_read(3'd0, d);
        check(tag, d, e);
    endtask

    // DATA read and push on the same edge: the pop is resolved before the push.
    task automatic read_and_push(input string tag, input logic [31:0] v);
        logic [31:0] e;
        model_pop(e);
        model_push(v);
        chipselect = 1'b1; read = 1'b1; address = 3'd0;
        in_port = v; in_valid = 1'b1;
        cycle();
        chipselect = 1'b0; read = 1'b0; in_valid = 1'b0;
        check(tag, readdata, e);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(3'd1, d);
        check(tag, d, exp_status());
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; in_port = '0; in_valid = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Reset state and underflow on empty read
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        bus_read(3'd1, d);
        check("rst_status", d, 32'h0000_0001);
        read_data("empty_data");
        bus_read(3'd1, d);
        check("udf_status", d, 32'h0000_0009);
        bus_write(3'd1, 32'h8);
        m_udf = 1'b0;
        check_status("udf_clear");

        // Basic ordering
        for (int i = 1; i <= 3; i++) push_sample(32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 3; i++) read_data($sformatf("fifo_order%0d", i));
        cycle();
        check("readdata_hold", readdata, 32'hA5A5_0003);
        check_status("level_zero");

        // Overflow: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) push_sample(32'h100 + 32'(i));
        bus_read(3'd1, d);
        check("full_ovf_status", d, 32'h0000_1016);
        bus_write(3'd1, 32'h4);
        m_ovf = 1'b0;
        check_status("ovf_w1c");

        // Push and pop together while full
        read_and_push("full_rd_push", 32'h1234);
        check_status("full_rd_push_status");
        for (int i = 0; i < DEPTH; i++) read_data($sformatf("drain%0d", i));
        check("last_drained", readdata, 32'h1234);

        // Push and pop together while empty
        read_and_push("empty_rd_push", 32'h77);
        check_status("empty_rd_push_status");
        read_data("empty_rd_push_data");
        bus_write(3'd1, 32'h8);
        m_udf = 1'b0;

        // Register readback, RAW and unused addresses
        bus_write(3'd3, 32'h4);
        m_thr = 4;
        bus_write(3'd2, 32'h2);
        bus_read(3'd3, d);
        check("thresh_rb", d, 32'h4);
        bus_read(3'd2, d);
        check("mask_rb", d, 32'h2);
        in_port = 32'hDEAD_BEEF;
        bus_read(3'd4, d);
        check("raw", d, 32'hDEAD_BEEF);
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, d);
        check("addr5", d, 32'h0);

        // Threshold interrupt
        for (int i = 0; i < 3; i++) push_sample(32'h200 + 32'(i));
        cycle();
        check("irq_below_thr", {31'b0, irq}, 32'h0);
        push_sample(32'h203);
        check("irq_lag", {31'b0, irq}, 32'h0);
        cycle();
        check("irq_at_thr", {31'b0, irq}, 32'h1);
        read_data("irq_pop");
        check("irq_pop_lag", {31'b0, irq}, 32'h1);
        cycle();
        check("irq_drop", {31'b0, irq}, 32'h0);

        // Reset mid-operation with a read in flight
        push_sample(32'h204);
        push_sample(32'h205);
        chipselect = 1'b1; read = 1'b1; address = 3'd0; reset = 1'b1;
        cycle();
        chipselect = 1'b0; read = 1'b0; reset = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_thr = DEPTH / 2;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check_status("midrst_status");
        bus_read(3'd3, d);
        check("midrst_thresh", d, 32'(DEPTH / 2));
        bus_read(3'd2, d);
        check("midrst_mask", d, 32'h0);
        push_sample(32'hBEE0);
        push_sample(32'hBEE1);
        read_data("post_rst0");
        read_data("post_rst1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
